burst_sequencer: RTL and testbench

Controls one address burst toward the MRAM interface. It latches a base address and burst length, then steps a beat counter. It drives the existing `Adder` (registered base + counter, 1-cycle latency) and presents each beat address to the memory side with a valid/ready handshake. It sits between the command front-end (which issues `start`) and the MRAM access logic (which consumes `burst_addr`).

---
 rtl/burst_pkg.sv | 27 ++
 rtl/burst_sequencer_adder.sv | 53 +++++
 rtl/burst_sequencer.sv | 136 +++++++++++++
 tb/tb_burst_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// ---------------------------------------------------------------------------
// burst_pkg
//
// Shared definitions for the MRAM burst path. Holds the sequencer state
// encoding and the default address/counter widths, so the command
// front-end and the burst sequencer agree on sizes without repeating them.
//
// Contents:
//   DEFAULT_ADDR_WIDTH    - default width of base and beat addresses
//   DEFAULT_COUNTER_WIDTH - default width of burst length and beat counter
//   state_t               - burst sequencer states IDLE/CALC/ISSUE/DONE
// ---------------------------------------------------------------------------
package burst_pkg;

  localparam int DEFAULT_ADDR_WIDTH    = 20;
  localparam int DEFAULT_COUNTER_WIDTH = 4;

  // CALC gives the Adder one cycle to register the next beat address,
  // ISSUE holds that address until memory accepts it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : burst_pkg

// File: rtl/burst_sequencer_adder.sv
// ---------------------------------------------------------------------------
// Adder
//
// Registered address adder: on a cycle with en=1 it stores
// initial_addr + counter (counter zero-extended, sum truncated so it wraps
// modulo 2^ADDR_WIDTH). The stored value is held while en=0.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-high reset, clears the register
//   en           in   load enable
//   initial_addr in   base address (ADDR_WIDTH)
//   counter      in   beat offset (COUNTER_WIDTH)
//   sum          out  registered address (ADDR_WIDTH)
// ---------------------------------------------------------------------------
module Adder
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDR_WIDTH-1:0]    initial_addr,
  input  logic [COUNTER_WIDTH-1:0] counter,
  output logic [ADDR_WIDTH-1:0]    sum
);

  logic [ADDR_WIDTH-1:0] sum_q;
  logic [ADDR_WIDTH-1:0] sum_d;

  // Next sum: the counter is zero-extended and any carry out of the top
  // bit is dropped, so addresses wrap around the top of the address space.
  always_comb begin
    sum_d = sum_q;
    if (en) begin
      sum_d = initial_addr + ADDR_WIDTH'(counter);
    end
  end

  // Address register; reset has priority over a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule : Adder

// File: rtl/burst_sequencer.sv
// ---------------------------------------------------------------------------
// burst_sequencer
//
// Runs one address burst toward the MRAM access logic. A start in IDLE
// latches the base address and length; the sequencer then alternates
// CALC (Adder registers base + beat index) and ISSUE (address presented
// with addr_valid until mem_ready) until the last beat is accepted, then
// pulses done for one cycle. Abort or reset return it to IDLE.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   start       in   request a burst, sampled only in IDLE
//   start_addr  in   base address, latched with start (ADDR_WIDTH)
//   burst_len   in   beats minus one, latched with start (COUNTER_WIDTH)
//   abort       in   end the current burst, no done pulse
//   mem_ready   in   memory accepts the current beat
//   addr_valid  out  burst_addr holds a valid beat address
//   burst_addr  out  current beat address (ADDR_WIDTH)
//   beat_cnt    out  index of the current beat (COUNTER_WIDTH)
//   busy        out  high in CALC and ISSUE
//   done        out  one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module burst_sequencer
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    start_addr,
  input  logic [COUNTER_WIDTH-1:0] burst_len,
  input  logic                     abort,
  input  logic                     mem_ready,
  output logic                     addr_valid,
  output logic [ADDR_WIDTH-1:0]    burst_addr,
  output logic [COUNTER_WIDTH-1:0] beat_cnt,
  output logic                     busy,
  output logic                     done
);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [COUNTER_WIDTH-1:0] len_q, len_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     lastBeat;
  logic                     adderEn;

  // The burst is complete once the beat whose index equals the latched
  // length is accepted; the counter therefore never has to wrap.
  assign lastBeat = (cnt_q == len_q);

  // Next-state logic. Base and length only change on an accepted start in
  // IDLE, so a start seen later in the burst cannot disturb it. An abort in
  // ISSUE takes priority over mem_ready: the beat counts as accepted by
  // memory, but the counter is not advanced since nothing more is issued.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d  = start_addr;
          len_d   = burst_len;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        state_d = abort ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          if (lastBeat) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + COUNTER_WIDTH'(1);
            state_d = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched burst parameters and beat counter. Reset wins at any
  // point in the burst and clears everything back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // The Adder loads only in CALC, which is why burst_addr stays frozen
  // through ISSUE and keeps its last value after the burst ends.
  assign adderEn = (state_q == CALC);

  Adder #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_adder (
    .clk          (clk),
    .rst          (rst),
    .en           (adderEn),
    .initial_addr (base_q),
    .counter      (cnt_q),
    .sum          (burst_addr)
  );

  // All status outputs decode straight from the registered state, so
  // addr_valid and done can never be high together.
  assign addr_valid = (state_q == ISSUE);
  assign busy       = (state_q == CALC) || (state_q == ISSUE);
  assign done       = (state_q == DONE);
  assign beat_cnt   = cnt_q;

endmodule : burst_sequencer

// File: tb/tb_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_burst_sequencer
//
// Directed bench for burst_sequencer. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that point, so each "cycle"
// below is the interval following an edge.
// ---------------------------------------------------------------------------
module tb_burst_sequencer;

  localparam int AW = 20;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] burst_len;
  logic          abort;
  logic          mem_ready;
  logic          addr_valid;
  logic [AW-1:0] burst_addr;
  logic [CW-1:0] beat_cnt;
  logic          busy;
  logic          done;

  int assertCount = 0;
  int failCount   = 0;

  burst_sequencer #(
    .ADDR_WIDTH    (AW),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .abort      (abort),
    .mem_ready  (mem_ready),
    .addr_valid (addr_valid),
    .burst_addr (burst_addr),
    .beat_cnt   (beat_cnt),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a burst in the current (IDLE) cycle and follows it to DONE,
  // recording every accepted beat. Optionally stalls one beat for a number
  // of cycles and/or asserts a competing start during beat 1.
  task automatic applyStimulus(input string name, input logic [AW-1:0] base,
                               input logic [CW-1:0] len, input int stallBeat,
                               input int stallCycles, input bit intrude,
                               input int expDone);
    logic [AW-1:0] addrs[$];
    int            cnts[$];
    int            cyc, doneCyc, stallLeft, overlap, heldCycles;
    bit            finished;
    logic [AW-1:0] expAddr;

    start      = 1'b1;
    start_addr = base;
    burst_len  = len;
    mem_ready  = 1'b1;
    abort      = 1'b0;
    tick();
    cyc        = 1;
    start      = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    checkOutput({name, " busy c1"}, 32'(busy), 32'd1);
    checkOutput({name, " valid c1"}, 32'(addr_valid), 32'd0);

    doneCyc    = -1;
    stallLeft  = stallCycles;
    overlap    = 0;
    heldCycles = 0;
    finished   = 1'b0;
    while (!finished && cyc < 80) begin
      start = 1'b0;
      if (done) begin
        doneCyc  = cyc;
        finished = 1'b1;
        if (addr_valid) overlap++;
      end
      if (addr_valid) begin
        if (int'(beat_cnt) == stallBeat) heldCycles++;
        if (intrude && beat_cnt == 4'd1) begin
          start      = 1'b1;
          start_addr = 20'hABCDE;
          burst_len  = 4'hF;
        end
        if (int'(beat_cnt) == stallBeat && stallLeft > 0) begin
          mem_ready = 1'b0;
          stallLeft--;
        end else begin
          mem_ready = 1'b1;
          addrs.push_back(burst_addr);
          cnts.push_back(int'(beat_cnt));
        end
      end else begin
        mem_ready = 1'b1;
      end
      if (!finished) begin
        tick();
        cyc++;
      end
    end

    start = 1'b0;
    tick();
    checkOutput({name, " done cycle"}, 32'(doneCyc), 32'(expDone));
    checkOutput({name, " valid with done"}, 32'(overlap), 32'd0);
    checkOutput({name, " busy after"}, 32'(busy), 32'd0);
    checkOutput({name, " done after"}, 32'(done), 32'd0);
    checkOutput({name, " beats"}, 32'(addrs.size()), 32'(int'(len) + 1));
    for (int i = 0; i < addrs.size(); i++) begin
      expAddr = base + AW'(i);
      checkOutput($sformatf("%s addr%0d", name, i), 32'(addrs[i]), 32'(expAddr));
      checkOutput($sformatf("%s cnt%0d", name, i), 32'(cnts[i]), 32'(i));
    end
    expAddr = base + AW'(len);
    checkOutput({name, " addr held"}, 32'(burst_addr), 32'(expAddr));
    if (stallBeat >= 0) begin
      checkOutput({name, " stall held"}, 32'(heldCycles), 32'(stallCycles + 1));
    end
  endtask

  initial begin
    bit found;

    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    abort      = 1'b0;
    mem_ready  = 1'b0;
    tick();
    tick();
    checkOutput("reset valid", 32'(addr_valid), 32'd0);
    checkOutput("reset addr", 32'(burst_addr), 32'd0);
    checkOutput("reset cnt", 32'(beat_cnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // start together with abort in IDLE must be ignored
    start      = 1'b1;
    abort      = 1'b1;
    start_addr = 20'h12345;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start+abort busy", 32'(busy), 32'd0);

    applyStimulus("single", 20'h00040, 4'd0, -1, 0, 1'b0, 3);
    applyStimulus("four", 20'h00010, 4'd3, -1, 0, 1'b0, 9);
    applyStimulus("backpressure", 20'h00010, 4'd3, 1, 3, 1'b0, 12);
    applyStimulus("wrap", 20'hFFFFE, 4'd3, -1, 0, 1'b0, 9);
    applyStimulus("intrude", 20'h00500, 4'd3, -1, 0, 1'b1, 9);

    // Abort during ISSUE of beat 2 of an 8-beat burst.
    start      = 1'b1;
    start_addr = 20'h00200;
    burst_len  = 4'd7;
    mem_ready  = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (addr_valid && beat_cnt == 4'd2) found = 1'b1;
      else tick();
    end
    checkOutput("abort reach beat2", 32'(found), 32'd1);
    checkOutput("abort beat2 addr", 32'(burst_addr), 32'h00202);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort valid", 32'(addr_valid), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    applyStimulus("after abort", 20'h00100, 4'd0, -1, 0, 1'b0, 3);

    // Reset pulsed in CALC of beat 1.
    start      = 1'b1;
    start_addr = 20'h00300;
    burst_len  = 4'd3;
    mem_ready  = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy && !addr_valid && beat_cnt == 4'd1) found = 1'b1;
      else tick();
    end
    checkOutput("rst reach calc1", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst valid", 32'(addr_valid), 32'd0);
    checkOutput("midrst addr", 32'(burst_addr), 32'd0);
    checkOutput("midrst cnt", 32'(beat_cnt), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    tick();
    applyStimulus("post reset", 20'h00777, 4'd1, -1, 0, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule : tb_burst_sequencer
